// File: rtl/mul_16_seq.sv
// mul_16_seq: multi-cycle shift-and-add 16x16 multiplier (low 16 bits) sharing one add_16.
module add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module mul_16_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d, sum;
  logic [4:0]  count_q, count_d;
  logic        last;
  add_16 u_add (.a(acc_q), .b(mcand_q), .sum(sum));
  // Early exit looks at the multiplier as it will be after this step's shift.
  assign last = (count_q == 5'd15) || (EARLY_EXIT && mplier_q[15:1] == 15'd0);
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        acc_d    = 16'd0;
        mcand_d  = a;
        mplier_d = b;
        count_d  = 5'd0;
      end
      RUN: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (last) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 16'd0;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      count_q   <= 5'd0;
      product_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_mul_16_seq.sv
// tb_mul_16_seq: directed vector table plus corner sequences for both EARLY_EXIT settings.
module tb_mul_16_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [15:0] a = 16'd0, b = 16'd0, product0, product1;
  logic        busy0, done0, busy1, done1;
  int          checks = 0, errors = 0;

  mul_16_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(product0));
  mul_16_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(product1));

  always #5 clk = ~clk;

  typedef struct {
    bit          e;
    logic [15:0] av, bv, p;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit e, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] pexp, input int lat, input bit noise);
    int n;
    string nm;
    nm = $sformatf("%s a=%h b=%h", e ? "early" : "fixed", av, bv);
    @(negedge clk);
    a = av; b = bv;
    if (e) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk({nm, " busy_after_accept"}, e ? busy1 : busy0, 1);
    n = 0;
    do begin
      if (noise) begin
        a = 16'($urandom); b = 16'($urandom);
        if (e) start1 = 1'($urandom_range(0, 1)); else start0 = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!(e ? done1 : done0) && n < 40);
    start0 = 1'b0; start1 = 1'b0;
    chk({nm, " latency"}, n, lat);
    chk({nm, " product"}, e ? product1 : product0, pexp);
    chk({nm, " busy_in_done"}, e ? busy1 : busy0, 1);
    if (noise) begin
      if (e) start1 = 1'b1; else start0 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk({nm, " busy_after_done"}, e ? busy1 : busy0, 0);
    chk({nm, " done_single_pulse"}, e ? done1 : done0, 0);
    if (noise) begin
      @(negedge clk);
      chk({nm, " no_queued_start"}, e ? busy1 : busy0, 0);
      chk({nm, " product_held"}, e ? product1 : product0, pexp);
    end
  endtask

  initial begin
    int t, last, ndone, lowc;
    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h000F, 16};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16};
    vecs[2] = '{1'b0, 16'h0100, 16'h0100, 16'h0000, 16};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16};
    vecs[4] = '{1'b1, 16'h0005, 16'h0003, 16'h000F, 2};
    vecs[5] = '{1'b1, 16'h1234, 16'h0000, 16'h0000, 1};
    vecs[6] = '{1'b1, 16'h0001, 16'h8000, 16'h8000, 16};
    vecs[7] = '{1'b1, 16'h0010, 16'h00FF, 16'h0FF0, 8};

    repeat (2) @(negedge clk);
    chk("reset busy0", busy0, 0);
    chk("reset done0", done0, 0);
    chk("reset product0", product0, 0);
    chk("reset busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle without start", busy0, 0);

    foreach (vecs[i]) run_op(vecs[i].e, vecs[i].av, vecs[i].bv, vecs[i].p, vecs[i].lat, 1'b0);

    // Operands and start toggle throughout the run; only the captured pair counts.
    run_op(1'b0, 16'h00AB, 16'h0123, 16'hC261, 16, 1'b1);

    @(negedge clk);
    a = 16'd7; b = 16'd9; start0 = 1'b1;
    t = 0; last = -1; ndone = 0; lowc = 0;
    while (ndone < 3 && t < 200) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (ndone > 0 && !busy0) lowc++;
      if (done0) begin
        chk("b2b product", product0, 16'h003F);
        if (last >= 0) chk("b2b interval", t - last, 18);
        last = t;
        ndone++;
        if (ndone == 3) start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    chk("b2b done count", ndone, 3);
    chk("b2b idle cycles", lowc, 2);
    repeat (2) @(negedge clk);
    chk("b2b drained", busy0, 0);

    @(negedge clk);
    a = 16'd100; b = 16'd200; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", busy0, 0);
    chk("async reset done", done0, 0);
    chk("async reset product", product0, 0);
    @(negedge clk);
    chk("held reset busy", busy0, 0);
    rst_n = 1'b1;
    run_op(1'b0, 16'd100, 16'd200, 16'h4E20, 16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
